csr_issue: RTL and testbench
============================

CSR_ISSUE -- requirements
Module: csr_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum TRAP-state cycles before abort (used only with CSR_TIMEOUT_EN).
REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- instr_valid  input  1  execute-stage instruction valid.
- instr  input  32  execute-stage instruction word.
- instr_pc  input  32  PC of instr.
- rs1_data  input  32  rs1 operand value.
- current_privilege  input  2  current privilege mode (2'b11 = M, 2'b00 = U).
- csr_r_data  input  32  read data from the CSR file.
- trap_csr_violation  input  1  CSR file privilege-violation flag.
- flush_trap  input  1  CSR file trap-entry flush.
- flush_from_interrupt  input  1  CSR file interrupt or MRET flush.
- next_pc_in  input  32  CSR file redirect target.
- csr_addr  output  12  CSR address.
- csr_func  output  3  CSR operation code.
- csr_w_data  output  32  register write operand.
- csr_imm  output  32  zero-extended immediate operand.
- csr_write_enable  output  1  CSR access strobe.
- trap_sources  output  1  synchronous-trap request.
- trap_instr_pc  output  32  PC of the trapping instruction.
- trap_cause  output  32  trap cause code.
- is_mret  output  1  MRET strobe.
- stall  output  1  holds the front of the pipeline.
- rd_we  output  1  register-file write enable.
- rd_addr  output  5  destination register.
- rd_data  output  32  destination register data.
- redirect_valid  output  1  PC redirect strobe.
- redirect_pc  output  32  PC redirect target.
- instr_correctly_executed  output  1  retire pulse to minstret.

Function
REQ-003 SHALL implement the states IDLE, ISSUE, WAIT and TRAP.
REQ-004 SHALL, in IDLE, accept an instruction when instr_valid=1 and instr[6:0]=7'b1110011; SHALL latch instr, instr_pc and rs1_data; SHALL go to ISSUE; SHALL ignore all other opcodes.
REQ-005 SHALL hold stall=1 combinationally in the accept cycle and in every cycle where state!=IDLE.
REQ-006 SHALL map ISA funct3 to csr_func as 001→001, 010→010, 011→011, 101→100, 110→101 and 111→110.
REQ-007 SHALL, for a CSR op in ISSUE, drive for exactly one cycle: csr_write_enable=1, csr_addr=instr[31:20], csr_w_data=latched rs1, csr_imm={27'b0,instr[19:15]}; then go to WAIT.
REQ-008 SHALL, in WAIT with trap_csr_violation=1, pulse trap_sources with trap_cause=2 and trap_instr_pc=latched PC, then go to TRAP.
REQ-009 SHALL, in WAIT with no violation, pulse rd_we (suppressed when rd_addr=0) with rd_data=csr_r_data, pulse instr_correctly_executed, then go to IDLE.
REQ-010 SHALL treat funct3=000 as follows:
- 0x00000073 (ECALL): cause 11 if privilege=11, else cause 8.
- 0x00100073 (EBREAK): cause 3.
- 0x30200073 (MRET): is_mret pulse.
- any other encoding, and funct3=100: cause 2 (illegal).
In each case SHALL raise the single-cycle strobe in ISSUE and go to TRAP.
REQ-011 SHALL, in TRAP, on the first cycle with flush_trap or flush_from_interrupt high, pulse redirect_valid with redirect_pc=next_pc_in and go to IDLE; SHALL also pulse instr_correctly_executed only for MRET.
REQ-012 SHALL, in IDLE, give flush_from_interrupt priority over acceptance: pulse redirect_valid with next_pc_in and accept nothing that cycle.
REQ-013 SHALL register all strobes and keep them single-cycle, with no back-to-back repeats.

Reset
REQ-014 SHALL, with reset=0 at a clock edge, set state=IDLE and drive every output to 0 (including mid-operation); the operation in flight is discarded and no strobe is emitted.

Configuration
REQ-015 SHALL, with CSR_TIMEOUT_EN defined, count cycles in TRAP; on reaching TIMEOUT_CYCLES with no flush, SHALL pulse redirect_valid with redirect_pc=latched PC+4 and return to IDLE; without the macro, SHALL wait in TRAP indefinitely and include no counter.

Structure
REQ-016 SHALL take the following from shared package csr_pkg: the SYSTEM opcode, funct3 constants, csr_func encodings, trap cause constants and the state enum.
REQ-017 SHALL place the combinational decode in one sub-module, csr_sys_decode.

Verification
REQ-018 CSRRW x5,0x305,x6 with rs1=0x80 → csr_func=001, csr_addr=0x305, csr_w_data=0x80; two cycles later rd_we=1, rd_addr=5.
REQ-019 CSRRSI x0,0x340,7 → csr_func=100 is NOT expected; csr_func=101, csr_imm=7, rd_we=0, one retire pulse.
REQ-020 ECALL at PC 0x100 with privilege=00 → trap_sources=1, trap_cause=8, trap_instr_pc=0x100; flush_trap with next_pc_in=0x200 → redirect_pc=0x200.
REQ-021 MRET → is_mret one cycle; flush_from_interrupt with next_pc_in=0x104 → redirect and a retire pulse.
REQ-022 CSR op with trap_csr_violation=1 → trap_cause=2 and no rd_we; reset=0 asserted in TRAP → IDLE with all outputs 0.
REQ-023 CSR_TIMEOUT_EN, ECALL at PC 0x40 with no flush for 16 cycles → redirect_pc=0x44.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants, state enum and registered-output bundle for the CSR/SYSTEM issue unit
package csr_pkg;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_RSVD   = 3'b100;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;
    localparam logic [2:0] FN_NONE = 3'b000;
    localparam logic [2:0] FN_RW   = 3'b001;
    localparam logic [2:0] FN_RS   = 3'b010;
    localparam logic [2:0] FN_RC   = 3'b011;
    localparam logic [2:0] FN_RWI  = 3'b100;
    localparam logic [2:0] FN_RSI  = 3'b101;
    localparam logic [2:0] FN_RCI  = 3'b110;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_MRET   = 32'h3020_0073;
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U    = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [1:0]  PRIV_M = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, TRAP} state_t;
    typedef struct packed {
        logic [11:0] csr_addr;
        logic [2:0]  csr_func;
        logic [31:0] csr_w_data;
        logic [31:0] csr_imm;
        logic        csr_write_enable;
        logic        trap_sources;
        logic [31:0] trap_instr_pc;
        logic [31:0] trap_cause;
        logic        is_mret;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        retire;
    } csr_out_t;
endpackage

// File: rtl/csr_sys_decode.sv
// csr_sys_decode: combinational classification of a latched SYSTEM instruction
module csr_sys_decode import csr_pkg::*; (
    input  logic [31:0] instr,
    input  logic [1:0]  privilege,
    output logic        is_csr,
    output logic        is_mret,
    output logic [2:0]  func,
    output logic [31:0] cause
);
    // translate ISA funct3 into the CSR file's operation code; PRIV/reserved map to none
    always_comb begin
        func = FN_NONE;
        case (instr[14:12])
            F3_CSRRW:          func = FN_RW;
            F3_CSRRS:          func = FN_RS;
            F3_CSRRC:          func = FN_RC;
            F3_CSRRWI:         func = FN_RWI;
            F3_CSRRSI:         func = FN_RSI;
            F3_CSRRCI:         func = FN_RCI;
            F3_PRIV, F3_RSVD:  func = FN_NONE;
            default:           func = FN_NONE;
        endcase
    end

    assign is_csr  = func != FN_NONE;
    assign is_mret = instr == INSN_MRET;
    assign cause   = instr == INSN_ECALL  ? (privilege == PRIV_M ? CAUSE_ECALL_M : CAUSE_ECALL_U) :
                     instr == INSN_EBREAK ? CAUSE_BREAKPOINT : CAUSE_ILLEGAL;
endmodule

// File: rtl/csr_issue.sv
// csr_issue: execute-stage sequencer for CSR accesses, ECALL/EBREAK/MRET and illegal SYSTEM ops.
// Optional TRAP-state watchdog enabled by defining CSR_TIMEOUT_EN.
module csr_issue import csr_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    input  logic [31:0] rs1_data,
    input  logic [1:0]  current_privilege,
    input  logic [31:0] csr_r_data,
    input  logic        trap_csr_violation,
    input  logic        flush_trap,
    input  logic        flush_from_interrupt,
    input  logic [31:0] next_pc_in,
    output logic [11:0] csr_addr,
    output logic [2:0]  csr_func,
    output logic [31:0] csr_w_data,
    output logic [31:0] csr_imm,
    output logic        csr_write_enable,
    output logic        trap_sources,
    output logic [31:0] trap_instr_pc,
    output logic [31:0] trap_cause,
    output logic        is_mret,
    output logic        stall,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        instr_correctly_executed
);
    state_t     state, state_n;
    csr_out_t   out_q, out_n;
    logic [31:0] instr_q, pc_q, rs1_q;
    logic        accept, timeout, dec_csr, dec_mret;
    logic [2:0]  dec_func;
    logic [31:0] dec_cause;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // a pending interrupt/MRET flush wins over taking a new instruction
    assign accept = reset && state == IDLE && !flush_from_interrupt && instr_valid && instr[6:0] == OPC_SYSTEM;
    assign stall  = reset && (accept || state != IDLE);

    csr_sys_decode u_dec (
        .instr     (instr_q),
        .privilege (current_privilege),
        .is_csr    (dec_csr),
        .is_mret   (dec_mret),
        .func      (dec_func),
        .cause     (dec_cause)
    );

`ifdef CSR_TIMEOUT_EN
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] trap_cnt;
    // count cycles spent waiting in TRAP; cleared whenever we are elsewhere
    always_ff @(posedge clk) trap_cnt <= (!reset || state != TRAP) ? '0 : trap_cnt + 1'b1;
    assign timeout = state == TRAP && int'(trap_cnt) == TIMEOUT_CYCLES - 1;
`else
    assign timeout = 1'b0;
`endif

    // capture the accepted instruction and its operands
    always_ff @(posedge clk) begin
        if (accept) begin
            instr_q <= instr;
            pc_q    <= instr_pc;
            rs1_q   <= rs1_data;
        end
    end

    // state and registered strobes; every strobe defaults low so it lasts one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            out_q <= '0;
        end else begin
            state <= state_n;
            out_q <= out_n;
        end
    end

    // next state and next strobe values
    always_comb begin
        state_n = state;
        out_n   = '0;
        case (state)
            IDLE: begin
                out_n.redirect_valid = flush_from_interrupt && !out_q.redirect_valid;
                out_n.redirect_pc    = (flush_from_interrupt && !out_q.redirect_valid) ? next_pc_in : '0;
                state_n              = accept ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (dec_csr) begin
                    out_n.csr_write_enable = 1'b1;
                    out_n.csr_addr         = instr_q[31:20];
                    out_n.csr_func         = dec_func;
                    out_n.csr_w_data       = rs1_q;
                    out_n.csr_imm          = {27'b0, instr_q[19:15]};
                    state_n                = WAIT;
                end else begin
                    out_n.is_mret       = dec_mret;
                    out_n.trap_sources  = !dec_mret;
                    out_n.trap_cause    = dec_mret ? '0 : dec_cause;
                    out_n.trap_instr_pc = dec_mret ? '0 : pc_q;
                    state_n             = TRAP;
                end
            end
            WAIT: begin
                if (trap_csr_violation) begin
                    out_n.trap_sources  = 1'b1;
                    out_n.trap_cause    = CAUSE_ILLEGAL;
                    out_n.trap_instr_pc = pc_q;
                    state_n             = TRAP;
                end else begin
                    out_n.rd_we   = |instr_q[11:7];
                    out_n.rd_addr = instr_q[11:7];
                    out_n.rd_data = csr_r_data;
                    out_n.retire  = 1'b1;
                    state_n       = IDLE;
                end
            end
            TRAP: begin
                if (flush_trap || flush_from_interrupt) begin
                    out_n.redirect_valid = 1'b1;
                    out_n.redirect_pc    = next_pc_in;
                    out_n.retire         = dec_mret;
                    state_n              = IDLE;
                end else if (timeout) begin
                    out_n.redirect_valid = 1'b1;
                    out_n.redirect_pc    = pc_q + 32'd4;
                    state_n              = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign csr_addr                 = out_q.csr_addr;
    assign csr_func                 = out_q.csr_func;
    assign csr_w_data               = out_q.csr_w_data;
    assign csr_imm                  = out_q.csr_imm;
    assign csr_write_enable         = out_q.csr_write_enable;
    assign trap_sources             = out_q.trap_sources;
    assign trap_instr_pc            = out_q.trap_instr_pc;
    assign trap_cause               = out_q.trap_cause;
    assign is_mret                  = out_q.is_mret;
    assign rd_we                    = out_q.rd_we;
    assign rd_addr                  = out_q.rd_addr;
    assign rd_data                  = out_q.rd_data;
    assign redirect_valid           = out_q.redirect_valid;
    assign redirect_pc              = out_q.redirect_pc;
    assign instr_correctly_executed = out_q.retire;
endmodule

// File: tb/tb_csr_issue.sv
// tb_csr_issue: directed bench with a cycle-timeline reference model for csr_issue
module tb_csr_issue;
    logic        clk = 0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr, instr_pc, rs1_data, csr_r_data, next_pc_in;
    logic [1:0]  current_privilege;
    logic        trap_csr_violation, flush_trap, flush_from_interrupt;
    logic [11:0] csr_addr;
    logic [2:0]  csr_func;
    logic [31:0] csr_w_data, csr_imm, trap_instr_pc, trap_cause, rd_data, redirect_pc;
    logic        csr_write_enable, trap_sources, is_mret, stall, rd_we, redirect_valid, instr_correctly_executed;
    logic [4:0]  rd_addr;

    csr_issue dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .rs1_data(rs1_data), .current_privilege(current_privilege), .csr_r_data(csr_r_data),
        .trap_csr_violation(trap_csr_violation), .flush_trap(flush_trap),
        .flush_from_interrupt(flush_from_interrupt), .next_pc_in(next_pc_in),
        .csr_addr(csr_addr), .csr_func(csr_func), .csr_w_data(csr_w_data), .csr_imm(csr_imm),
        .csr_write_enable(csr_write_enable), .trap_sources(trap_sources), .trap_instr_pc(trap_instr_pc),
        .trap_cause(trap_cause), .is_mret(is_mret), .stall(stall), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_data(rd_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_correctly_executed(instr_correctly_executed)
    );

    always #5 clk = ~clk;

    // expected output vector for one cycle
    typedef struct packed {
        logic        stall;
        logic        we;
        logic [11:0] addr;
        logic [2:0]  func;
        logic [31:0] wdata;
        logic [31:0] imm;
        logic        trap;
        logic [31:0] tpc;
        logic [31:0] cause;
        logic        mret;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rv;
        logic [31:0] rpc;
        logic        ret;
    } ev_t;

    localparam logic [2:0] FMAP [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd6};

    ev_t  exp_m [int];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   run = 0;
    int   ts;
    bit   ts_mret;
    logic [31:0] cap_stall, cap_we, cap_func, cap_addr, cap_wdata, cap_imm, cap_trap, cap_cause, cap_tpc, cap_mret;
    logic [31:0] cap_rd_we, cap_rd_addr, cap_rd_data, cap_ret, cap_rv, cap_rpc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t get(input int c);
        return exp_m.exists(c) ? exp_m[c] : ev_t'('0);
    endfunction

    // kind: 0 = CSR access, 1 = synchronous trap, 2 = MRET
    function automatic void model_dec(input logic [31:0] w, input logic [1:0] p,
                                      output int kind, output logic [2:0] fn, output logic [31:0] cause);
        fn = FMAP[w[14:12]];
        cause = 0;
        kind = 0;
        if (w[14:12] == 3'd0 || w[14:12] == 3'd4) begin
            kind  = (w == 32'h3020_0073) ? 2 : 1;
            cause = (w == 32'h0000_0073) ? (p == 2'b11 ? 32'd11 : 32'd8) :
                    (w == 32'h0010_0073) ? 32'd3 : 32'd2;
        end
    endfunction

    task automatic mark_stall(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            ev_t e = get(c);
            e.stall = 1'b1;
            exp_m[c] = e;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    // every cycle: DUT outputs against the timeline model (all zero unless scheduled)
    always @(negedge clk) begin
        ev_t g, e;
        if (run) begin
            g = {stall, csr_write_enable, csr_addr, csr_func, csr_w_data, csr_imm, trap_sources,
                 trap_instr_pc, trap_cause, is_mret, rd_we, rd_addr, rd_data, redirect_valid,
                 redirect_pc, instr_correctly_executed};
            e = get(cyc);
            checks++;
            if (g === e) passes++;
            else $display("FAIL cycle %0d outputs got %h want %h", cyc, g, e);
        end
    end

    task automatic issue(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] rs, input logic viol);
        int kind, k;
        logic [2:0] fn;
        logic [31:0] cs;
        ev_t e;
        step();
        k = cyc;
        instr_valid = 1; instr = w; instr_pc = pc; rs1_data = rs;
        model_dec(w, current_privilege, kind, fn, cs);
        ts_mret = kind == 2;
        if (kind == 0) begin
            mark_stall(k, viol ? k + 3 : k + 2);
            e = get(k + 2);
            e.we = 1; e.addr = w[31:20]; e.func = fn; e.wdata = rs; e.imm = {27'b0, w[19:15]};
            exp_m[k + 2] = e;
            e = get(k + 3);
            if (viol) begin
                e.trap = 1; e.tpc = pc; e.cause = 32'd2; ts = k + 3;
            end else begin
                e.rd_we = |w[11:7]; e.rd_addr = w[11:7]; e.rd_data = csr_r_data; e.ret = 1;
            end
            exp_m[k + 3] = e;
        end else begin
            mark_stall(k, k + 3);
            e = get(k + 2);
            if (kind == 2) e.mret = 1;
            else begin e.trap = 1; e.tpc = pc; e.cause = cs; end
            exp_m[k + 2] = e;
            ts = k + 2;
        end
        #1 cap_stall = {31'b0, stall};
        step();
        instr_valid = 0; instr = 0; instr_pc = 0; rs1_data = 0;
        step();
        trap_csr_violation = viol;
        cap_we = {31'b0, csr_write_enable}; cap_func = {29'b0, csr_func}; cap_addr = {20'b0, csr_addr};
        cap_wdata = csr_w_data; cap_imm = csr_imm; cap_trap = {31'b0, trap_sources};
        cap_cause = trap_cause; cap_tpc = trap_instr_pc; cap_mret = {31'b0, is_mret};
        step();
        trap_csr_violation = 0;
        cap_rd_we = {31'b0, rd_we}; cap_rd_addr = {27'b0, rd_addr}; cap_rd_data = rd_data;
        cap_ret = {31'b0, instr_correctly_executed};
        if (viol) begin
            cap_trap = {31'b0, trap_sources}; cap_cause = trap_cause; cap_tpc = trap_instr_pc;
        end
    endtask

    task automatic trap_flush(input int n, input bit irq, input logic [31:0] npc);
        int f;
        ev_t e;
        f = ts + n;
        mark_stall(cyc, f);
        while (cyc < f) step();
        if (irq) flush_from_interrupt = 1; else flush_trap = 1;
        next_pc_in = npc;
        e = get(f + 1);
        e.rv = 1; e.rpc = npc; e.ret = ts_mret;
        exp_m[f + 1] = e;
        step();
        flush_trap = 0; flush_from_interrupt = 0; next_pc_in = 0;
        cap_rv = {31'b0, redirect_valid}; cap_rpc = redirect_pc; cap_ret = {31'b0, instr_correctly_executed};
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ev_t e;
        int c;
        reset = 0; instr_valid = 0; instr = 0; instr_pc = 0; rs1_data = 0; csr_r_data = 0;
        next_pc_in = 0; current_privilege = 2'b11; trap_csr_violation = 0; flush_trap = 0;
        flush_from_interrupt = 0;
        step();
        run = 1;
        step();
        instr_valid = 1; instr = 32'h305312F3;
        #1 lit("reset_stall", {31'b0, stall}, 0);
        lit("reset_we", {31'b0, csr_write_enable}, 0);
        instr_valid = 0; instr = 0;
        step();
        reset = 1;

        step();
        instr_valid = 1; instr = 32'h0000_0013;
        step();
        instr_valid = 0; instr = 0;
        step();

        csr_r_data = 32'h1234_5678;
        issue(32'h305312F3, 32'h10, 32'h80, 0);
        lit("csrrw_stall", cap_stall, 1);
        lit("csrrw_func", cap_func, 32'h1);
        lit("csrrw_addr", cap_addr, 32'h305);
        lit("csrrw_wdata", cap_wdata, 32'h80);
        lit("csrrw_rd_we", cap_rd_we, 1);
        lit("csrrw_rd_addr", cap_rd_addr, 5);
        lit("csrrw_rd_data", cap_rd_data, 32'h1234_5678);

        csr_r_data = 32'h0000_CAFE;
        issue(32'h3403E073, 32'h14, 32'h0, 0);
        lit("csrrsi_func", cap_func, 32'h5);
        lit("csrrsi_imm", cap_imm, 7);
        lit("csrrsi_rd_we", cap_rd_we, 0);
        lit("csrrsi_ret", cap_ret, 1);

        current_privilege = 2'b00;
        issue(32'h0000_0073, 32'h100, 0, 0);
        lit("ecall_u_trap", cap_trap, 1);
        lit("ecall_u_cause", cap_cause, 8);
        lit("ecall_u_pc", cap_tpc, 32'h100);
        trap_flush(3, 0, 32'h200);
        lit("ecall_u_redirect", cap_rpc, 32'h200);
        lit("ecall_u_ret", cap_ret, 0);

        current_privilege = 2'b11;
        issue(32'h0000_0073, 32'h180, 0, 0);
        lit("ecall_m_cause", cap_cause, 11);
        trap_flush(1, 1, 32'h300);

        issue(32'h0010_0073, 32'h1C0, 0, 0);
        lit("ebreak_cause", cap_cause, 3);
        trap_flush(2, 0, 32'h340);

        issue(32'h3020_0073, 32'h200, 0, 0);
        lit("mret_pulse", cap_mret, 1);
        lit("mret_no_trap", cap_trap, 0);
        trap_flush(2, 1, 32'h104);
        lit("mret_redirect", cap_rpc, 32'h104);
        lit("mret_ret", cap_ret, 1);

        issue(32'h1050_0073, 32'h220, 0, 0);
        lit("wfi_illegal", cap_cause, 2);
        trap_flush(1, 0, 32'h400);
        issue(32'h0000_4073, 32'h224, 0, 0);
        lit("f3_100_illegal", cap_cause, 2);
        trap_flush(1, 1, 32'h404);

        step();
        c = cyc;
        instr_valid = 1; instr = 32'h305312F3; flush_from_interrupt = 1; next_pc_in = 32'h500;
        e = get(c + 1); e.rv = 1; e.rpc = 32'h500; exp_m[c + 1] = e;
        step();
        lit("irq_idle_rv", {31'b0, redirect_valid}, 1);
        lit("irq_idle_pc", redirect_pc, 32'h500);
        step();
        instr_valid = 0; instr = 0; flush_from_interrupt = 0; next_pc_in = 0;
        lit("irq_idle_no_repeat", {31'b0, redirect_valid}, 0);
        step();

        issue(32'h3000B3F3, 32'h20, 32'h55, 1);
        lit("viol_cause", cap_cause, 2);
        lit("viol_pc", cap_tpc, 32'h20);
        lit("viol_rd_we", cap_rd_we, 0);
        mark_stall(cyc, cyc + 1);
        step();
        step();
        reset = 0;
        #1 lit("trap_reset_stall", {31'b0, stall}, 0);
        step();
        lit("trap_reset_rv", {31'b0, redirect_valid}, 0);
        lit("trap_reset_trap", {31'b0, trap_sources}, 0);
        reset = 1;
        csr_r_data = 32'h0000_00AA;
        issue(32'h305312F3, 32'h30, 32'h7, 0);
        lit("after_reset_rd_we", cap_rd_we, 1);

`ifdef CSR_TIMEOUT_EN
        current_privilege = 2'b00;
        issue(32'h0000_0073, 32'h40, 0, 0);
        mark_stall(cyc, ts + 15);
        e = get(ts + 16); e.rv = 1; e.rpc = 32'h44; exp_m[ts + 16] = e;
        while (cyc < ts + 16) step();
        lit("timeout_rv", {31'b0, redirect_valid}, 1);
        lit("timeout_pc", redirect_pc, 32'h44);
`endif

        step();
        step();
        run = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
